mod_counter: RTL and testbench
==============================

# mod_counter

Parameterised up/down modulo counter: the general-purpose successor to the plain binary up-counter, used for timers, baud/refresh dividers and event counting. It adds:
- a runtime modulus;
- direction control;
- parallel load;
- wrap/saturate/one-shot modes;
- a registered carry/borrow pulse for cascading;
- an optional clock-enable prescaler.

## Interface
- WIDTH, 8, counter width in bits (≥1).
- PRESCALE_WIDTH, 4, prescaler width in bits (used only with COUNTER_PRESCALE_EN).
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  count qualifier; a step is taken only in cycles where Enable=1.
- Up  input  1  1 = count up, 0 = count down; sampled on each step.
- Mode  input  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap.
- Clear  input  1  synchronous clear of Count, Done and the prescaler.
- Load  input  1  synchronous parallel load.
- LoadValue  input  WIDTH  value loaded when Load=1.
- MaxVal  input  WIDTH  terminal value; the count range is 0..MaxVal.
- Prescale  input  PRESCALE_WIDTH  step every Prescale+1 enabled cycles (present only with COUNTER_PRESCALE_EN).
- Count  output  WIDTH  registered count value.
- Carry  output  1  registered one-cycle pulse marking a wrap (up) or borrow (down).
- AtTerminal  output  1  combinational: (Up && Count>=MaxVal) || (!Up && Count==0).
- Done  output  1  registered, sticky: one-shot has reached its terminal.

## Operation
- Per-cycle priority: Reset > Clear > Load > step > hold.
- Reset or Clear: Count=0, Carry=0, Done=0, prescaler=0.
- Load: Count = min(LoadValue, MaxVal); Done=0; Carry=0; prescaler=0. No step is taken in that cycle.
- Step condition: Enable && tick && !Done.
  - tick=1 every cycle when the prescaler is absent.
- Up step:
  - If Count < MaxVal: Count+1.
  - Otherwise, by Mode:
    - wrap: Count=0, Carry=1.
    - saturate: hold.
    - one-shot: hold, Done=1.
- Down step:
  - If Count > 0: Count−1.
  - Otherwise, by Mode:
    - wrap: Count = MaxVal, Carry=1.
    - saturate: hold at 0.
    - one-shot: hold, Done=1.
- Carry is 0 in every cycle not described above, so it is never held for two cycles by a single event.
- Arithmetic is WIDTH-bit unsigned. The comparison Count>=MaxVal means that lowering MaxVal below Count makes the next up step terminal. No intermediate out-of-range values are produced.
- MaxVal=0: Count stays 0. In wrap mode every step pulses Carry.
- Done blocks all steps until Clear, Load or Reset. Changing Mode does not clear Done.
- Up and Mode may change on any cycle and take effect on the next step.

## Timing
- Reset value of every output: Count=0, Carry=0, Done=0.
  - AtTerminal follows from Count and Up after reset (1 when Up=0).
- Latency: Count, Carry and Done update on the rising edge after the qualifying inputs. AtTerminal has zero latency.
- Carry is high in the same cycle that Count shows the wrapped value (0 or MaxVal).
- One-shot: Done rises on the edge of the terminal step. Count is unchanged on that edge because it is already at the terminal value.
- Reset asserted mid-count or mid-prescale: everything returns to its reset value on the next edge. No partial prescale survives.

## Configuration
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - The Prescale port and a PRESCALE_WIDTH-bit divider exist.
  - The divider increments on each cycle with Enable && !Done.
  - tick=1 when divider==Prescale; the divider then returns to 0.
  - Prescale=0 gives a step on every enabled cycle.
  - Reducing Prescale below the current divider value forces tick on the next enabled cycle.
  - Clear, Load and Reset zero the divider.
- Undefined: no Prescale port and no divider logic; tick is tied to 1.

## Test plan
- Reset=1 for 2 cycles, then Enable=1, Up=1, Mode=00, MaxVal=5, for 8 cycles.
  - Required: Count 0,1,2,3,4,5,0,1,2.
  - Carry high only in the cycle Count returns to 0.
  - AtTerminal high while Count=5.
- Load=1, LoadValue=3, then Up=0, Mode=00, MaxVal=9, Enable=1.
  - Required: Count 3,2,1,0,9,8.
  - Carry high with the 9.
  - LoadValue=12 with MaxVal=9 loads 9.
- Mode=01, Up=1, MaxVal=3, Enable held.
  - Required: Count saturates at 3; Carry never asserts.
  - Then Up=0: Count walks to 0 and holds.
- Mode=10, Up=1, MaxVal=2.
  - Required: Count 0,1,2; Done=1 on the next step and Count stays 2.
  - Load=1, LoadValue=0 clears Done and the count restarts.
- Simultaneous Clear=1, Load=1 and a step while Count=4.
  - Required: Count=0 and Done=0 next cycle (Clear wins).
  - Reset=1 asserted mid-prescale returns all outputs to 0.
- With COUNTER_PRESCALE_EN, Prescale=2, MaxVal=3, Up=1, Enable=1.
  - Required: Count advances every 3rd cycle (0,0,0,1,1,1,2…).
  - Enable=0 for 5 cycles freezes both Count and the divider.

Source files
------------

// File: rtl/mod_counter_if.sv
// mod_counter control/status bundle.
// Prescale field exists only with COUNTER_PRESCALE_EN.
interface mod_counter_if #(
  parameter int WIDTH = 8
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE_WIDTH = 4
`endif
);
  logic             i_enable;
  logic             i_up;
  logic [1:0]       i_mode;
  logic             i_clear;
  logic             i_load;
  logic [WIDTH-1:0] i_load_value;
  logic [WIDTH-1:0] i_max_val;
`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] i_prescale;
`endif
  logic [WIDTH-1:0] o_count;
  logic             o_carry;
  logic             o_at_terminal;
  logic             o_done;

  modport master (
    output i_enable, i_up, i_mode, i_clear,
    output i_load, i_load_value, i_max_val,
`ifdef COUNTER_PRESCALE_EN
    output i_prescale,
`endif
    input  o_count, o_carry, o_at_terminal, o_done
  );

  modport slave (
    input  i_enable, i_up, i_mode, i_clear,
    input  i_load, i_load_value, i_max_val,
`ifdef COUNTER_PRESCALE_EN
    input  i_prescale,
`endif
    output o_count, o_carry, o_at_terminal, o_done
  );
endinterface

// File: rtl/mod_counter.sv
// Up/down modulo counter: wrap/saturate/one-shot, carry pulse.
// Optional clock-enable prescaler under COUNTER_PRESCALE_EN.
module mod_counter #(
  parameter int WIDTH = 8
`ifdef COUNTER_PRESCALE_EN
  , parameter int PRESCALE_WIDTH = 4
`endif
) (
  input  logic         i_clk,
  input  logic         i_rst,
  mod_counter_if.slave bus
);
  localparam logic [1:0] MODE_SAT = 2'b01;
  localparam logic [1:0] MODE_ONE = 2'b10;

  logic [WIDTH-1:0] r_count;
  logic             r_carry;
  logic             r_done;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_carry_nxt;
  logic             w_done_nxt;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_tick;
  logic             w_step;
  logic             w_sat;
  logic             w_one;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESCALE_WIDTH-1:0] r_div;
  logic [PRESCALE_WIDTH-1:0] w_div_nxt;

  // >= so a lowered Prescale ticks on the next enabled cycle
  assign w_tick = (r_div >= bus.i_prescale);

  // divider advances only while enabled and not done
  always_comb begin
    w_div_nxt = r_div;
    if (bus.i_clear || bus.i_load) begin
      w_div_nxt = '0;
    end else if (bus.i_enable && !r_done) begin
      w_div_nxt = w_tick ? '0 : r_div + PRESCALE_WIDTH'(1);
    end
  end

  // divider register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_div <= '0;
    else       r_div <= w_div_nxt;
  end
`else
  assign w_tick = 1'b1;
`endif

  assign w_sat  = (bus.i_mode == MODE_SAT);
  assign w_one  = (bus.i_mode == MODE_ONE);
  assign w_step = bus.i_enable && w_tick && !r_done;
  assign w_load_sat = (bus.i_load_value > bus.i_max_val)
                    ? bus.i_max_val : bus.i_load_value;

  // next count/carry/done: clear > load > step > hold
  always_comb begin
    w_count_nxt = r_count;
    w_carry_nxt = 1'b0;
    w_done_nxt  = r_done;
    if (bus.i_clear) begin
      w_count_nxt = '0;
      w_done_nxt  = 1'b0;
    end else if (bus.i_load) begin
      w_count_nxt = w_load_sat;
      w_done_nxt  = 1'b0;
    end else if (w_step) begin
      if (bus.i_up) begin
        if (r_count < bus.i_max_val) begin
          w_count_nxt = r_count + WIDTH'(1);
        end else if (w_one) begin
          w_done_nxt = 1'b1;
        end else if (!w_sat) begin
          w_count_nxt = '0;
          w_carry_nxt = 1'b1;
        end
      end else begin
        if (r_count != '0) begin
          w_count_nxt = r_count - WIDTH'(1);
        end else if (w_one) begin
          w_done_nxt = 1'b1;
        end else if (!w_sat) begin
          w_count_nxt = bus.i_max_val;
          w_carry_nxt = 1'b1;
        end
      end
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_carry <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_carry <= w_carry_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.o_count = r_count;
  assign bus.o_carry = r_carry;
  assign bus.o_done  = r_done;
  assign bus.o_at_terminal =
    (bus.i_up && (r_count >= bus.i_max_val)) ||
    (!bus.i_up && (r_count == '0));
endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter.
// Prescale scenario runs only with COUNTER_PRESCALE_EN.
module tb_mod_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

`ifdef COUNTER_PRESCALE_EN
  mod_counter_if #(.WIDTH(8), .PRESCALE_WIDTH(4)) bus ();
  mod_counter #(.WIDTH(8), .PRESCALE_WIDTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );
`else
  mod_counter_if #(.WIDTH(8)) bus ();
  mod_counter #(.WIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus.slave)
  );
`endif

  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_up = 1'b0;
    edge1();
    edge1();
    checks += 4;
    if (bus.o_count !== 8'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", bus.o_count);
    end
    if (bus.o_carry !== 1'b0) begin
      errors++; $display("FAIL reset_carry got %b exp 0", bus.o_carry);
    end
    if (bus.o_done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b exp 0", bus.o_done);
    end
    if (bus.o_at_terminal !== 1'b1) begin
      errors++; $display("FAIL reset_atterm got %b exp 1", bus.o_at_terminal);
    end
  endtask

  task automatic test_wrap_up();
    int ec[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
    rst = 1'b0;
    bus.i_enable = 1'b1;
    bus.i_up = 1'b1;
    bus.i_mode = 2'b00;
    bus.i_max_val = 8'd5;
    for (int i = 0; i < 8; i++) begin
      edge1();
      checks += 3;
      if (bus.o_count !== 8'(ec[i])) begin
        errors++;
        $display("FAIL wrap_count[%0d] got %0d exp %0d", i, bus.o_count, ec[i]);
      end
      if (bus.o_carry !== (i == 5)) begin
        errors++;
        $display("FAIL wrap_carry[%0d] got %b exp %b", i, bus.o_carry, i == 5);
      end
      if (bus.o_at_terminal !== (ec[i] == 5)) begin
        errors++;
        $display("FAIL wrap_atterm[%0d] got %b", i, bus.o_at_terminal);
      end
    end
  endtask

  task automatic test_load_down();
    int ec[5] = '{2, 1, 0, 9, 8};
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd3;
    bus.i_up = 1'b0;
    bus.i_mode = 2'b00;
    bus.i_max_val = 8'd9;
    edge1();
    bus.i_load = 1'b0;
    checks++;
    if (bus.o_count !== 8'd3) begin
      errors++; $display("FAIL load3 got %0d exp 3", bus.o_count);
    end
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks += 2;
      if (bus.o_count !== 8'(ec[i])) begin
        errors++;
        $display("FAIL down_count[%0d] got %0d exp %0d", i, bus.o_count, ec[i]);
      end
      if (bus.o_carry !== (i == 3)) begin
        errors++;
        $display("FAIL down_carry[%0d] got %b exp %b", i, bus.o_carry, i == 3);
      end
    end
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd12;
    edge1();
    bus.i_load = 1'b0;
    checks++;
    if (bus.o_count !== 8'd9) begin
      errors++; $display("FAIL load_clamp got %0d exp 9", bus.o_count);
    end
  endtask

  task automatic test_saturate();
    int eu[5] = '{1, 2, 3, 3, 3};
    int ed[5] = '{2, 1, 0, 0, 0};
    bus.i_mode = 2'b01;
    bus.i_up = 1'b1;
    bus.i_max_val = 8'd3;
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd0;
    edge1();
    bus.i_load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks += 2;
      if (bus.o_count !== 8'(eu[i])) begin
        errors++;
        $display("FAIL sat_up[%0d] got %0d exp %0d", i, bus.o_count, eu[i]);
      end
      if (bus.o_carry !== 1'b0) begin
        errors++; $display("FAIL sat_carry[%0d] got %b exp 0", i, bus.o_carry);
      end
    end
    bus.i_up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge1();
      checks += 2;
      if (bus.o_count !== 8'(ed[i])) begin
        errors++;
        $display("FAIL sat_dn[%0d] got %0d exp %0d", i, bus.o_count, ed[i]);
      end
      if (bus.o_carry !== 1'b0) begin
        errors++; $display("FAIL sat_dcarry[%0d] got %b exp 0", i, bus.o_carry);
      end
    end
  endtask

  task automatic test_oneshot();
    int ec[4] = '{1, 2, 2, 2};
    int ed[4] = '{0, 0, 1, 1};
    bus.i_mode = 2'b10;
    bus.i_up = 1'b1;
    bus.i_max_val = 8'd2;
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd0;
    edge1();
    bus.i_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      edge1();
      checks += 2;
      if (bus.o_count !== 8'(ec[i])) begin
        errors++;
        $display("FAIL os_count[%0d] got %0d exp %0d", i, bus.o_count, ec[i]);
      end
      if (bus.o_done !== 1'(ed[i])) begin
        errors++;
        $display("FAIL os_done[%0d] got %b exp %0d", i, bus.o_done, ed[i]);
      end
    end
    bus.i_mode = 2'b00;
    edge1();
    checks += 2;
    if (bus.o_done !== 1'b1 || bus.o_count !== 8'd2) begin
      errors++;
      $display("FAIL os_sticky got done=%b cnt=%0d exp 1/2",
               bus.o_done, bus.o_count);
    end
    if (bus.o_carry !== 1'b0) begin
      errors++; $display("FAIL os_nocarry got %b exp 0", bus.o_carry);
    end
    bus.i_mode = 2'b10;
    bus.i_load = 1'b1;
    edge1();
    bus.i_load = 1'b0;
    checks++;
    if (bus.o_done !== 1'b0 || bus.o_count !== 8'd0) begin
      errors++;
      $display("FAIL os_reload got done=%b cnt=%0d exp 0/0",
               bus.o_done, bus.o_count);
    end
    edge1();
    checks++;
    if (bus.o_count !== 8'd1) begin
      errors++; $display("FAIL os_restart got %0d exp 1", bus.o_count);
    end
  endtask

  task automatic test_clear_priority();
    bus.i_mode = 2'b00;
    bus.i_up = 1'b1;
    bus.i_max_val = 8'd9;
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd4;
    edge1();
    bus.i_load = 1'b0;
    checks++;
    if (bus.o_count !== 8'd4) begin
      errors++; $display("FAIL pre_clear got %0d exp 4", bus.o_count);
    end
    bus.i_clear = 1'b1;
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd7;
    edge1();
    bus.i_clear = 1'b0;
    bus.i_load = 1'b0;
    checks++;
    if (bus.o_count !== 8'd0 || bus.o_done !== 1'b0) begin
      errors++;
      $display("FAIL clear_wins got cnt=%0d done=%b exp 0/0",
               bus.o_count, bus.o_done);
    end
  endtask

  task automatic test_boundaries();
    bus.i_load = 1'b1;
    bus.i_load_value = 8'd4;
    edge1();
    bus.i_load = 1'b0;
    bus.i_max_val = 8'd2;
    #1;
    checks++;
    if (bus.o_at_terminal !== 1'b1) begin
      errors++; $display("FAIL lowmax_atterm got %b exp 1", bus.o_at_terminal);
    end
    edge1();
    checks++;
    if (bus.o_count !== 8'd0 || bus.o_carry !== 1'b1) begin
      errors++;
      $display("FAIL lowmax_wrap got cnt=%0d c=%b exp 0/1",
               bus.o_count, bus.o_carry);
    end
    edge1();
    checks++;
    if (bus.o_count !== 8'd1 || bus.o_carry !== 1'b0) begin
      errors++;
      $display("FAIL lowmax_next got cnt=%0d c=%b exp 1/0",
               bus.o_count, bus.o_carry);
    end
    bus.i_max_val = 8'd0;
    for (int i = 0; i < 3; i++) begin
      edge1();
      checks++;
      if (bus.o_count !== 8'd0 || bus.o_carry !== 1'b1) begin
        errors++;
        $display("FAIL max0[%0d] got cnt=%0d c=%b exp 0/1",
                 i, bus.o_count, bus.o_carry);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.i_max_val = 8'd9;
    edge1();
    edge1();
    checks++;
    if (bus.o_count !== 8'd2) begin
      errors++; $display("FAIL mid_pre got %0d exp 2", bus.o_count);
    end
    rst = 1'b1;
    edge1();
    checks++;
    if (bus.o_count !== 8'd0 || bus.o_carry !== 1'b0 || bus.o_done !== 1'b0)
    begin
      errors++;
      $display("FAIL mid_reset got cnt=%0d c=%b d=%b exp 0/0/0",
               bus.o_count, bus.o_carry, bus.o_done);
    end
    rst = 1'b0;
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    int ec[4] = '{0, 0, 1, 1};
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    bus.i_prescale = 4'd2;
    bus.i_max_val = 8'd3;
    bus.i_up = 1'b1;
    bus.i_mode = 2'b00;
    bus.i_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      edge1();
      checks++;
      if (bus.o_count !== 8'(ec[i])) begin
        errors++;
        $display("FAIL ps_count[%0d] got %0d exp %0d", i, bus.o_count, ec[i]);
      end
    end
    bus.i_enable = 1'b0;
    for (int i = 0; i < 5; i++) edge1();
    checks++;
    if (bus.o_count !== 8'd1) begin
      errors++; $display("FAIL ps_freeze got %0d exp 1", bus.o_count);
    end
    bus.i_enable = 1'b1;
    edge1();
    checks++;
    if (bus.o_count !== 8'd1) begin
      errors++; $display("FAIL ps_resume0 got %0d exp 1", bus.o_count);
    end
    edge1();
    checks++;
    if (bus.o_count !== 8'd2) begin
      errors++; $display("FAIL ps_resume1 got %0d exp 2", bus.o_count);
    end
    edge1();
    rst = 1'b1;
    edge1();
    rst = 1'b0;
    checks++;
    if (bus.o_count !== 8'd0) begin
      errors++; $display("FAIL ps_reset got %0d exp 0", bus.o_count);
    end
    edge1();
    edge1();
    checks++;
    if (bus.o_count !== 8'd0) begin
      errors++; $display("FAIL ps_nopartial got %0d exp 0", bus.o_count);
    end
    edge1();
    checks++;
    if (bus.o_count !== 8'd1) begin
      errors++; $display("FAIL ps_after_rst got %0d exp 1", bus.o_count);
    end
  endtask
`endif

  initial begin
    bus.i_enable = 1'b0;
    bus.i_up = 1'b0;
    bus.i_mode = 2'b00;
    bus.i_clear = 1'b0;
    bus.i_load = 1'b0;
    bus.i_load_value = 8'd0;
    bus.i_max_val = 8'd0;
`ifdef COUNTER_PRESCALE_EN
    bus.i_prescale = 4'd0;
`endif
    test_reset();
    test_wrap_up();
    test_load_down();
    test_saturate();
    test_oneshot();
    test_clear_priority();
    test_boundaries();
    test_reset_mid();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
